// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider, z = a / b.
// Radix-2 restoring mantissa division, one quotient bit per enabled cycle, fixed latency.
module fp_div_iter #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        start,
    input  logic [sig_width+ex_width:0] a,
    input  logic [sig_width+ex_width:0] b,
    input  logic [2:0]                  round,
    output logic                        busy,
    output logic                        done,
    output logic [sig_width+ex_width:0] z,
    output logic [7:0]                  status
);
    localparam int W  = sig_width + ex_width + 1;
    localparam int MW = sig_width + 1;
    localparam int Q  = sig_width + 3;
    localparam int EW = ex_width + 2;
    localparam int CW = $clog2(Q);
    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (ex_width - 1)) - 1);
    localparam logic signed [EW-1:0] EZ_MAX = EW'((1 << ex_width) - 1);
    localparam logic signed [EW-1:0] EZ_ONE = EW'(1);
    localparam logic [CW-1:0]        LAST   = CW'(Q - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic [2:0]           round_q, round_d;
    logic signed [EW-1:0] ez_q, ez_d;
    logic [MW:0]          rem_q, rem_d;
    logic [Q-1:0]         quo_q, quo_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [W-1:0]         z_q, z_d;
    logic [7:0]           status_q, status_d;

    // Operand classification on the captured operands
    logic [ex_width-1:0] ea, eb;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sz;

    always_comb begin
        ea     = a_q[W-2 -: ex_width];
        eb     = b_q[W-2 -: ex_width];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (&ea) && (a_q[sig_width-1:0] == '0);
        b_inf  = (&eb) && (b_q[sig_width-1:0] == '0);
        a_nan  = (&ea) && (a_q[sig_width-1:0] != '0);
        b_nan  = (&eb) && (b_q[sig_width-1:0] != '0);
        sz     = a_q[W-1] ^ b_q[W-1];
    end

    // The first step compares the dividend itself, later steps the doubled remainder
    logic [MW:0] mb, trial;
    logic        fits;

    always_comb begin
        mb    = {1'b0, 1'b1, b_q[sig_width-1:0]};
        trial = (cnt_q == '0) ? rem_q : {rem_q[MW-1:0], 1'b0};
        fits  = (trial >= mb);
    end

    logic [MW-1:0]        mant;
    logic [MW:0]          mant_r;
    logic                 guard, sticky, inc, oflow, uflow, to_inf;
    logic signed [EW-1:0] ez_norm, ez_rnd;
    logic [sig_width-1:0] frac;
    logic [W-1:0]         z_fin;
    logic [7:0]           st_fin;

    always_comb begin
        if (quo_q[Q-1]) begin
            mant    = quo_q[Q-1 -: MW];
            guard   = quo_q[1];
            sticky  = quo_q[0] | (|rem_q);
            ez_norm = ez_q;
        end else begin
            mant    = quo_q[Q-2 -: MW];
            guard   = quo_q[0];
            sticky  = |rem_q;
            ez_norm = ez_q - EZ_ONE;
        end

        case (round_q)
            3'd1:    inc = 1'b0;
            3'd2:    inc = ~sz & (guard | sticky);
            3'd3:    inc = sz & (guard | sticky);
            3'd4:    inc = guard;
            3'd5:    inc = guard | sticky;
            default: inc = guard & (sticky | mant[0]);
        endcase

        mant_r = {1'b0, mant} + {{MW{1'b0}}, inc};
        if (mant_r[MW]) begin
            frac   = mant_r[MW-1:1];
            ez_rnd = ez_norm + EZ_ONE;
        end else begin
            frac   = mant_r[sig_width-1:0];
            ez_rnd = ez_norm;
        end

        oflow = (ez_rnd >= EZ_MAX);
        uflow = (ez_norm < EZ_ONE) || (ez_rnd < EZ_ONE);
        case (round_q)
            3'd1:    to_inf = 1'b0;
            3'd2:    to_inf = ~sz;
            3'd3:    to_inf = sz;
            default: to_inf = 1'b1;
        endcase

        z_fin  = {sz, ez_rnd[ex_width-1:0], frac};
        st_fin = {2'b00, guard | sticky, 5'b00000};
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            z_fin  = {1'b0, {ex_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
            st_fin = 8'h04;
        end else if (a_inf) begin
            z_fin  = {sz, {ex_width{1'b1}}, {sig_width{1'b0}}};
            st_fin = 8'h02;
        end else if (b_zero) begin
            z_fin  = {sz, {ex_width{1'b1}}, {sig_width{1'b0}}};
            st_fin = 8'h82;
        end else if (b_inf | a_zero) begin
            z_fin  = {sz, {(W-1){1'b0}}};
            st_fin = 8'h01;
        end else if (oflow) begin
            if (to_inf) begin
                z_fin  = {sz, {ex_width{1'b1}}, {sig_width{1'b0}}};
                st_fin = 8'h32;
            end else begin
                z_fin  = {sz, {(ex_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};
                st_fin = 8'h30;
            end
        end else if (uflow) begin
            z_fin  = {sz, {(W-1){1'b0}}};
            st_fin = 8'h29;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        round_d  = round_q;
        ez_d     = ez_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        busy_d   = busy_q;
        done_d   = done_q;
        z_d      = z_q;
        status_d = status_q;
        if (enable) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_DIV;
                        busy_d  = 1'b1;
                        a_d     = a;
                        b_d     = b;
                        round_d = round;
                        ez_d    = $signed({2'b00, a[W-2 -: ex_width]})
                                - $signed({2'b00, b[W-2 -: ex_width]}) + BIAS;
                        rem_d   = {2'b01, a[sig_width-1:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_DIV: begin
                    rem_d = fits ? (trial - mb) : trial;
                    quo_d = {quo_q[Q-2:0], fits};
                    if (cnt_q == LAST) begin
                        state_d = S_FIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FIN: begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    z_d      = z_fin;
                    status_d = st_fin;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            round_q  <= '0;
            ez_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            z_q      <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            round_q  <= round_d;
            ez_q     <= ez_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            z_q      <= z_d;
            status_q <= status_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign z      = z_q;
    assign status = status_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: randomized and directed checks of fp_div_iter against an
// integer-arithmetic reference divider, plus handshake/timing scenarios.
module tb_fp_div_iter;
    logic        clk, resetn, enable, start;
    logic [31:0] a, b, z;
    logic [2:0]  rnd;
    logic        busy, done;
    logic [7:0]  status;

    int vectors = 0;
    int miscompares = 0;

    fp_div_iter dut (
        .clk(clk), .resetn(resetn), .enable(enable), .start(start),
        .a(a), .b(b), .round(rnd),
        .busy(busy), .done(done), .z(z), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [2:0]  rm;
        logic [31:0] exp_z;
        logic [7:0]  exp_s;
    } vec_t;

    // Reference: exact integer long division, then normalize/round/exceptions
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    input logic [2:0] rm,
                                    output logic [31:0] zr, output logic [7:0] sr);
        int     ex, ey, e, mode;
        bit     s, xnan, ynan, xinf, yinf, xz, yz, g, st, up, pre_uf, inf_dir;
        longint mx, my, q, r, mant;
        ex   = int'(x[30:23]);
        ey   = int'(y[30:23]);
        s    = x[31] ^ y[31];
        xnan = (ex == 255) && (x[22:0] != 0);
        ynan = (ey == 255) && (y[22:0] != 0);
        xinf = (ex == 255) && (x[22:0] == 0);
        yinf = (ey == 255) && (y[22:0] == 0);
        xz   = (ex == 0);
        yz   = (ey == 0);
        mode = (rm > 3'd5) ? 0 : int'(rm);
        if (xnan || ynan || (xz && yz) || (xinf && yinf)) begin
            zr = 32'h7FC00000; sr = 8'h04; return;
        end
        if (xinf) begin zr = {s, 8'hFF, 23'h0}; sr = 8'h02; return; end
        if (yz)   begin zr = {s, 8'hFF, 23'h0}; sr = 8'h82; return; end
        if (yinf || xz) begin zr = {s, 31'h0}; sr = 8'h01; return; end
        mx = longint'({1'b1, x[22:0]});
        my = longint'({1'b1, y[22:0]});
        q  = (mx << 25) / my;
        r  = (mx << 25) % my;
        e  = ex - ey + 127;
        if (q >= (64'sd1 << 25)) begin
            mant = q >> 2; g = q[1]; st = q[0] || (r != 0);
        end else begin
            mant = q >> 1; g = q[0]; st = (r != 0); e = e - 1;
        end
        pre_uf = (e <= 0);
        case (mode)
            0:       up = g && (st || mant[0]);
            1:       up = 1'b0;
            2:       up = !s && (g || st);
            3:       up = s && (g || st);
            4:       up = g;
            default: up = g || st;
        endcase
        mant = mant + (up ? 1 : 0);
        if (mant == (64'sd1 << 24)) begin mant = 64'sd1 << 23; e = e + 1; end
        inf_dir = (mode == 0) || (mode == 4) || (mode == 5) || (mode == 2 && !s) || (mode == 3 && s);
        if (e >= 255) begin
            if (inf_dir) begin zr = {s, 8'hFF, 23'h0};     sr = 8'h32; end
            else         begin zr = {s, 8'hFE, 23'h7FFFFF}; sr = 8'h30; end
        end else if (pre_uf || e <= 0) begin
            zr = {s, 31'h0}; sr = 8'h29;
        end else begin
            zr = {s, e[7:0], mant[22:0]};
            sr = (g || st) ? 8'h20 : 8'h00;
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = $urandom_range(0, 9);
        f = 23'($urandom);
        if ($urandom_range(0, 7) == 0) f = '1;
        case (k)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
            2:       e = 8'($urandom_range(200, 254));
            3:       e = 8'($urandom_range(1, 60));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Launch one operation and observe it; no comparisons here
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] rm,
                          output logic [31:0] zo, output logic [7:0] so,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        a = xa; b = xb; rnd = rm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; rnd = 3'($urandom);
        busy_ok = (busy === 1'b1);
        lat = -1; zo = '0; so = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n; zo = z; so = status;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        if (lat > 0 && busy !== 1'b0) busy_ok = 1'b0;
        $display("op a=%h b=%h rm=%0d -> z=%h status=%h latency=%0d", xa, xb, rm, zo, so, lat);
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; start = 1'b0; a = '0; b = '0; rnd = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, z, status} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b z=%h status=%h want all 0", busy, done, z, status);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        vec_t        tv [11];
        logic [31:0] zo;
        logic [7:0]  so;
        int          lat;
        bit          bok;
        tv = '{
            '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00},
            '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 8'h20},
            '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 8'h20},
            '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 8'h82},
            '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04},
            '{32'h7F800000, 32'h3F800000, 3'd0, 32'h7F800000, 8'h02},
            '{32'h7F000000, 32'h00800000, 3'd0, 32'h7F800000, 8'h32},
            '{32'h7F000000, 32'h00800000, 3'd1, 32'h7F7FFFFF, 8'h30},
            '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 8'h29},
            '{32'hC0C00000, 32'h40000000, 3'd0, 32'hC0400000, 8'h00},
            '{32'hFF000000, 32'h00800000, 3'd2, 32'hFF7FFFFF, 8'h30}
        };
        foreach (tv[i]) begin
            run_op(tv[i].op_a, tv[i].op_b, tv[i].rm, zo, so, lat, bok);
            vectors++;
            if (zo !== tv[i].exp_z) begin
                miscompares++;
                $display("FAIL directed[%0d] z: got %h want %h", i, zo, tv[i].exp_z);
            end
            vectors++;
            if (so !== tv[i].exp_s) begin
                miscompares++;
                $display("FAIL directed[%0d] status: got %h want %h", i, so, tv[i].exp_s);
            end
            vectors++;
            if (lat !== 27) begin
                miscompares++;
                $display("FAIL directed[%0d] latency: got %0d want 27", i, lat);
            end
            vectors++;
            if (bok !== 1'b1) begin
                miscompares++;
                $display("FAIL directed[%0d] busy_window: got %b want 1", i, bok);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] xa, xb, zo, ze;
        logic [7:0]  so, se;
        logic [2:0]  rm;
        int          lat;
        bit          bok;
        for (int i = 0; i < 40; i++) begin
            xa = rand_fp();
            xb = rand_fp();
            rm = 3'($urandom_range(0, 7));
            ref_div(xa, xb, rm, ze, se);
            run_op(xa, xb, rm, zo, so, lat, bok);
            vectors++;
            if (zo !== ze || so !== se) begin
                miscompares++;
                $display("FAIL random[%0d] a=%h b=%h rm=%0d: got z=%h status=%h want z=%h status=%h",
                         i, xa, xb, rm, zo, so, ze, se);
            end
            vectors++;
            if (lat !== 27) begin
                miscompares++;
                $display("FAIL random[%0d] latency: got %0d want 27", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xa, xb, zo, ze;
        logic [7:0]  so, se;
        int          ndone, first, lat;
        bit          done28, bok;
        xa = 32'h41200000; xb = 32'h40400000;
        ref_div(xa, xb, 3'd0, ze, se);
        @(negedge clk);
        a = xa; b = xb; rnd = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first = -1; done28 = 1'b0; zo = '0; so = '0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            start = (n == 5);
            if (n == 5) begin a = 32'h3F800000; b = 32'h00000000; end
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) begin first = n; zo = z; so = status; end
                if (n == 28) done28 = 1'b1;
            end
        end
        start = 1'b0;
        $display("op a=%h b=%h rm=0 (start re-asserted at E5) -> z=%h status=%h latency=%0d dones=%0d",
                 xa, xb, zo, so, first, ndone);
        vectors++;
        if (ndone !== 1 || first !== 27) begin
            miscompares++;
            $display("FAIL busy_start_ignored: got dones=%0d first=%0d want dones=1 first=27", ndone, first);
        end
        vectors++;
        if (zo !== ze || so !== se) begin
            miscompares++;
            $display("FAIL busy_start_result: got z=%h status=%h want z=%h status=%h", zo, so, ze, se);
        end
        vectors++;
        if (done28 !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: got done=1 at E28 want 0");
        end
        // Two operations at the earliest restart edge
        for (int i = 0; i < 2; i++) begin
            xa = rand_fp(); xb = rand_fp();
            ref_div(xa, xb, 3'd5, ze, se);
            run_op(xa, xb, 3'd5, zo, so, lat, bok);
            vectors++;
            if (zo !== ze || so !== se || lat !== 27) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: got z=%h status=%h lat=%0d want z=%h status=%h lat=27",
                         i, zo, so, lat, ze, se);
            end
        end
    endtask

    task automatic test_enable();
        logic [31:0] xa, xb, zo, ze;
        logic [7:0]  so, se;
        int          first;
        xa = 32'h3FC00000; xb = 32'h3F400000;
        ref_div(xa, xb, 3'd0, ze, se);
        @(negedge clk);
        a = xa; b = xb; rnd = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first = -1; zo = '0; so = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            enable = !(n >= 11 && n <= 13);
            @(posedge clk); #1;
            if (done === 1'b1) begin first = n; zo = z; so = status; break; end
        end
        $display("op a=%h b=%h rm=0 (enable low 3 cycles) -> z=%h status=%h latency=%0d", xa, xb, zo, so, first);
        vectors++;
        if (first !== 30) begin
            miscompares++;
            $display("FAIL enable_latency: got %0d want 30", first);
        end
        vectors++;
        if (zo !== ze || so !== se) begin
            miscompares++;
            $display("FAIL enable_result: got z=%h status=%h want z=%h status=%h", zo, so, ze, se);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_hold_frozen: got done=%b want 1", done);
        end
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_release: got done=%b want 0", done);
        end
    endtask

    task automatic test_abort();
        logic [31:0] xa, xb, zo, ze;
        logic [7:0]  so, se;
        int          ndone, lat;
        bit          bok;
        @(negedge clk);
        a = 32'h40490FDB; b = 32'h402DF854; rnd = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        vectors++;
        if ({busy, done, z, status} !== 42'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b done=%b z=%h status=%h want all 0", busy, done, z, status);
        end
        @(negedge clk);
        resetn = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        $display("op a=40490fdb b=402df854 rm=0 (reset at E10) -> dones=%0d", ndone);
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d dones want 0", ndone);
        end
        xa = 32'h40490FDB; xb = 32'hC02DF854;
        ref_div(xa, xb, 3'd3, ze, se);
        run_op(xa, xb, 3'd3, zo, so, lat, bok);
        vectors++;
        if (zo !== ze || so !== se || lat !== 27) begin
            miscompares++;
            $display("FAIL after_abort: got z=%h status=%h lat=%0d want z=%h status=%h lat=27",
                     zo, so, lat, ze, se);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_enable();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
